pmp_access_ctrl: RTL and testbench
==================================

Name: pmp_access_ctrl

Overview:
- Initiator side of the PMP check interface: arbitrates instruction-fetch and data requests, presents each to the pmp block as addr/oper/size/priv_mode and samples the returned permission.
- Granted accesses go to the memory port; denied, misaligned or timed-out accesses return a RISC-V exception cause and tval to the core.
- Sits between the core's fetch/LSU and the memory interface, alongside pmp.

Parameters:
- TIMEOUT, 64: max cycles in WAIT_MEM before a bus timeout; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch request valid
- if_ready  out  1  fetch request accepted
- if_addr  in  32  fetch address; always a word access
- d_valid  in  1  data request valid
- d_ready  out  1  data request accepted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- priv_mode  in  2  current privilege, sampled at accept
- pmp_addr  out  32  address to pmp.addr
- pmp_oper  out  2  READ/WRITE/EXECUTE to pmp.oper
- pmp_size  out  2  to pmp.size
- pmp_priv  out  2  to pmp.priv_mode
- pmp_perm  in  2  pmp.permission; 2'b01 = granted, any other value = denied
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_size  out  2  memory access size
- mem_rsp_valid  in  1  memory response or write acknowledge
- mem_rdata  in  32  memory read data
- rsp_valid  out  1  one-cycle response pulse to core
- rsp_port  out  1  0 = fetch, 1 = data
- rsp_fault  out  1  exception flag
- rsp_cause  out  4  mcause code
- rsp_rdata  out  32  read data; 0 on fault
- rsp_tval  out  32  faulting address; 0 if no fault

Behaviour:
- Reset, asynchronous, while reset = 0:
  - state = IDLE.
  - All outputs 0; pmp_oper = READ.
  - Timeout counter = 0; last_grant = data.
- Reset asserted mid-operation aborts the transaction; no response is generated.
- Single outstanding transaction. if_ready/d_ready are high only in IDLE, and only for the port granted that cycle.
- Arbitration in IDLE:
  - If only one port is valid, it is granted.
  - If both are valid, the port not in last_grant wins (alternating).
  - last_grant updates on accept.
- Accept latches addr, we, wdata, size (fetch forces size = 10) and priv_mode into internal registers.
- Operation mapping: fetch -> EXECUTE; load -> READ; store -> WRITE.
- State machine:
  - IDLE -> CHECK on accept.
  - CHECK lasts exactly 1 cycle. pmp_* outputs are driven from the latched registers in this state and hold until the next accept. The controller samples pmp_perm at the end of CHECK.
    - Misaligned access (half with addr[0] = 1; word with addr[1:0] != 0; size 11) -> FAULT. The misaligned check takes priority over PMP.
    - Otherwise perm = 01 -> ISSUE; any other perm -> FAULT.
  - ISSUE: mem_req_valid = 1 with mem_* from the latched registers; hold until mem_req_ready. On the ready cycle -> WAIT_MEM with counter cleared.
  - WAIT_MEM: counter increments each cycle.
    - mem_rsp_valid -> RESP; mem_rsp_valid wins over a same-cycle timeout.
    - Counter == TIMEOUT-1 with no response -> FAULT (access fault).
  - RESP: rsp_valid = 1 for 1 cycle; rsp_rdata = mem_rdata, captured in WAIT_MEM; 0 for stores. -> IDLE.
  - FAULT: rsp_valid = 1 for 1 cycle; rsp_fault = 1; rsp_tval = latched addr. -> IDLE.
- Cause codes:
  - Fetch: misaligned 0, access 1.
  - Load: misaligned 4, access 5.
  - Store: misaligned 6, access 7.
- Store with a fault never asserts mem_req_valid.
- Latency:
  - Granted access: accept to rsp_valid = 3 cycles + memory ready wait + memory response wait.
  - Fault from CHECK: rsp_valid 2 cycles after accept.
- A new request can be accepted in the cycle after rsp_valid.

Test Plan:
- Fetch at addr 0x20000000, perm = 01, mem_req_ready = 1, response 1 cycle later with 0xDEADBEEF -> pmp_oper = EXECUTE; rsp_valid with rdata 0xDEADBEEF, fault 0; 4 cycles from accept.
- Store word to 0x20000001 -> rsp_fault = 1, cause 6, tval 0x20000001; pmp_perm ignored; mem_req_valid never asserted.
- Load half from 0x30000000 with perm = 00 -> cause 5, tval 0x30000000; rsp_rdata = 0.
- if_valid and d_valid held high continuously, all granted -> grants alternate data, fetch, data, fetch; rsp_port toggles each response.
- Load granted, mem_rsp_valid never returns, TIMEOUT = 64 -> fault cause 5 exactly 64 cycles after entering WAIT_MEM.
- Reset driven low while in ISSUE -> mem_req_valid = 0 immediately; no rsp_valid; after release, a new request is accepted normally.

Source files
------------

// File: rtl/pmp_access_ctrl.sv
// -----------------------------------------------------------------------------
// pmp_access_ctrl
//
// Initiator side of the PMP check interface. Arbitrates between the core's
// instruction-fetch port and its data (load/store) port, presents the
// accepted request to the pmp block and samples the returned permission.
// Granted accesses go out on the memory port. Misaligned, denied or
// timed-out accesses return a RISC-V exception cause and tval instead.
// Only one transaction is outstanding at a time.
//
// pmp_oper encoding: 2'b00 READ, 2'b01 WRITE, 2'b10 EXECUTE.
//
// Ports
//   clock, reset          system clock; asynchronous active-low reset
//   if_valid/if_ready     fetch request handshake; if_addr is always a word
//   d_valid/d_ready       data request handshake
//   d_we, d_addr,         store flag, address, store data and size
//   d_wdata, d_size         (size 00 byte, 01 half, 10 word, 11 illegal)
//   priv_mode             current privilege, latched at accept
//   pmp_addr/oper/        request presented to the pmp block
//   pmp_size/pmp_priv
//   pmp_perm              pmp verdict, 2'b01 = granted, anything else denied
//   mem_req_*, mem_we,    memory request channel
//   mem_addr, mem_wdata,
//   mem_size
//   mem_rsp_valid,        memory response / write acknowledge
//   mem_rdata
//   rsp_*                 one-cycle response pulse to the core
// -----------------------------------------------------------------------------
module pmp_access_ctrl #(
    parameter int TIMEOUT = 64,   // max cycles in WAIT_MEM, 0 disables
    parameter int CNT_W   = 8     // timeout counter width, must hold TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_addr,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,

    input  logic [1:0]  priv_mode,

    output logic [31:0] pmp_addr,
    output logic [1:0]  pmp_oper,
    output logic [1:0]  pmp_size,
    output logic [1:0]  pmp_priv,
    input  logic [1:0]  pmp_perm,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,

    output logic        rsp_valid,
    output logic        rsp_port,
    output logic        rsp_fault,
    output logic [3:0]  rsp_cause,
    output logic [31:0] rsp_rdata,
    output logic [31:0] rsp_tval
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT_MEM,
        S_RESP,
        S_FAULT
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_EXEC  = 2'b10;

    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] PERM_OK   = 2'b01;

    // Counter value on the last WAIT_MEM cycle before a timeout fault.
    localparam int               TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TO_LAST);

    state_t             state_q, state_d;

    // Latched request, held from accept until the next accept.
    logic               port_q;        // 0 = fetch, 1 = data
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         size_q;
    logic [1:0]         priv_q;
    logic [1:0]         oper_q;

    logic               last_grant_q;  // 0 = fetch, 1 = data
    logic               mis_q;         // fault is a misalignment, not access
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        rdata_q;

    logic               grant_fetch;
    logic               grant_data;
    logic               accept;
    logic               misaligned;
    logic               timeout_hit;
    logic [3:0]         cause_base;

    // -------------------------------------------------------------------------
    // Arbitration: a lone valid port wins; with both valid, the port that was
    // not granted last time wins.
    // -------------------------------------------------------------------------
    assign grant_fetch = if_valid && (!d_valid || last_grant_q);
    assign grant_data  = d_valid  && (!if_valid || !last_grant_q);

    assign if_ready = (state_q == S_IDLE) && grant_fetch;
    assign d_ready  = (state_q == S_IDLE) && grant_data;
    assign accept   = if_ready || d_ready;

    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = (addr_q[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_CNT);

    // Even base code per port; access faults are base + 1.
    assign cause_base = !port_q ? 4'd0 : (we_q ? 4'd6 : 4'd4);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_CHECK;
            end
            S_CHECK: begin
                // Misalignment is decided before the pmp verdict is looked at.
                if (misaligned || (pmp_perm != PERM_OK)) state_d = S_FAULT;
                else                                     state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (mem_req_ready) state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                // A response in the timeout cycle still counts as a response.
                if (mem_rsp_valid)    state_d = S_RESP;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // pmp_* follow the latched request; they are valid from CHECK onward and
    // hold until the next accept.
    assign pmp_addr = addr_q;
    assign pmp_oper = oper_q;
    assign pmp_size = size_q;
    assign pmp_priv = priv_q;

    always_comb begin
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_size      = '0;
        rsp_valid     = 1'b0;
        rsp_port      = 1'b0;
        rsp_fault     = 1'b0;
        rsp_cause     = '0;
        rsp_rdata     = '0;
        rsp_tval      = '0;
        case (state_q)
            S_ISSUE: begin
                mem_req_valid = 1'b1;
                mem_we        = we_q;
                mem_addr      = addr_q;
                mem_wdata     = wdata_q;
                mem_size      = size_q;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_port  = port_q;
                rsp_rdata = rdata_q;
            end
            S_FAULT: begin
                rsp_valid = 1'b1;
                rsp_port  = port_q;
                rsp_fault = 1'b1;
                rsp_cause = cause_base + {3'b000, !mis_q};
                rsp_tval  = addr_q;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            priv_q       <= '0;
            oper_q       <= OP_READ;
            last_grant_q <= 1'b1;
            mis_q        <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                port_q       <= d_ready;
                we_q         <= d_ready && d_we;
                addr_q       <= d_ready ? d_addr  : if_addr;
                wdata_q      <= d_ready ? d_wdata : '0;
                size_q       <= d_ready ? d_size  : SIZE_WORD;
                priv_q       <= priv_mode;
                oper_q       <= !d_ready ? OP_EXEC : (d_we ? OP_WRITE : OP_READ);
                last_grant_q <= d_ready;
                mis_q        <= 1'b0;
            end

            if (state_q == S_CHECK) begin
                mis_q <= misaligned;
            end

            if ((state_q == S_ISSUE) && mem_req_ready) begin
                cnt_q <= '0;
            end

            if (state_q == S_WAIT_MEM) begin
                cnt_q <= cnt_q + 1'b1;
                if (mem_rsp_valid) begin
                    // Stores return zero regardless of what the bus drives.
                    rdata_q <= we_q ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_pmp_access_ctrl.sv
module tb_pmp_access_ctrl;

    localparam int TIMEOUT = 64;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_EXEC  = 2'b10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_addr = '0;
    logic        d_valid = 1'b0;
    logic        d_ready;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_size = '0;
    logic [1:0]  priv_mode = '0;
    logic [31:0] pmp_addr;
    logic [1:0]  pmp_oper;
    logic [1:0]  pmp_size;
    logic [1:0]  pmp_priv;
    logic [1:0]  pmp_perm;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_port;
    logic        rsp_fault;
    logic [3:0]  rsp_cause;
    logic [31:0] rsp_rdata;
    logic [31:0] rsp_tval;

    pmp_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_addr       (if_addr),
        .d_valid       (d_valid),
        .d_ready       (d_ready),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_size        (d_size),
        .priv_mode     (priv_mode),
        .pmp_addr      (pmp_addr),
        .pmp_oper      (pmp_oper),
        .pmp_size      (pmp_size),
        .pmp_priv      (pmp_priv),
        .pmp_perm      (pmp_perm),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_size      (mem_size),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_port      (rsp_port),
        .rsp_fault     (rsp_fault),
        .rsp_cause     (rsp_cause),
        .rsp_rdata     (rsp_rdata),
        .rsp_tval      (rsp_tval)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Per-transaction environment configuration (pmp verdict, memory timing)
    // -------------------------------------------------------------------------
    logic [1:0]  cfg_perm  = 2'b01;
    int          cfg_rw    = 0;     // ISSUE cycles with ready low
    int          cfg_w     = 0;     // WAIT_MEM cycles before the response
    bit          cfg_nores = 1'b0;  // memory never answers
    logic [31:0] cfg_rdata = '0;

    // pmp and memory responder
    initial begin
        int rdy_cnt;
        int widx;
        bit in_wait;
        bit hs_prev;
        rdy_cnt = 0; widx = 0; in_wait = 1'b0; hs_prev = 1'b0;
        pmp_perm = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clock); #1;
            pmp_perm      = cfg_perm;
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
            if (!reset) begin
                rdy_cnt = 0; in_wait = 1'b0; hs_prev = 1'b0; mem_req_ready = 1'b0;
            end else begin
                if (hs_prev) begin in_wait = 1'b1; widx = 0; end
                if (in_wait) begin
                    if (!cfg_nores && widx == cfg_w) begin
                        mem_rsp_valid = 1'b1;
                        mem_rdata     = cfg_rdata;
                        in_wait       = 1'b0;
                    end else begin
                        widx++;
                        if (widx == TIMEOUT) in_wait = 1'b0;
                    end
                end
                if (mem_req_valid) begin
                    mem_req_ready = (rdy_cnt == cfg_rw);
                    rdy_cnt++;
                end else begin
                    mem_req_ready = 1'b0;
                    rdy_cnt = 0;
                end
                hs_prev = mem_req_valid && mem_req_ready;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Transaction-level reference model and per-cycle compare
    // -------------------------------------------------------------------------
    bit          m_pending = 1'b0;
    int          m_rsp_cyc = 0;
    bit          m_port, m_fault;
    logic [3:0]  m_cause;
    logic [31:0] m_rdata, m_tval;
    bit          m_issue = 1'b0;
    int          m_iss_lo = 0, m_iss_hi = 0;
    bit          m_last = 1'b1;
    logic [31:0] m_paddr = '0;
    logic [1:0]  m_poper = OP_READ, m_psize = '0, m_ppriv = '0;
    bit          m_mwe;
    logic [31:0] m_maddr, m_mwdata;
    logic [1:0]  m_msize;

    bit          e_idle, e_gf, e_gd, e_mreq, e_rsp;
    bit          a_we, a_mis;
    logic [31:0] a_addr;
    logic [1:0]  a_size;
    logic [3:0]  a_base;

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
            check("rst_ready", 32'({if_ready, d_ready}), 32'd0);
            check("rst_pmp_addr", pmp_addr, 32'd0);
            check("rst_pmp_oper", 32'(pmp_oper), 32'(OP_READ));
            check("rst_mem_addr", mem_addr, 32'd0);
            check("rst_rsp_tval", rsp_tval, 32'd0);
            m_pending = 1'b0; m_issue = 1'b0; m_last = 1'b1;
            m_paddr = '0; m_poper = OP_READ; m_psize = '0; m_ppriv = '0;
        end else begin
            e_idle = !m_pending;
            e_gf   = if_valid && (!d_valid || m_last);
            e_gd   = d_valid && (!if_valid || !m_last);
            check("if_ready", 32'(if_ready), 32'(e_idle && e_gf));
            check("d_ready", 32'(d_ready), 32'(e_idle && e_gd));

            check("pmp_addr", pmp_addr, m_paddr);
            check("pmp_oper", 32'(pmp_oper), 32'(m_poper));
            check("pmp_size", 32'(pmp_size), 32'(m_psize));
            check("pmp_priv", 32'(pmp_priv), 32'(m_ppriv));

            e_mreq = m_pending && m_issue && cyc >= m_iss_lo && cyc <= m_iss_hi;
            check("mem_req_valid", 32'(mem_req_valid), 32'(e_mreq));
            if (e_mreq) begin
                check("mem_addr", mem_addr, m_maddr);
                check("mem_we", 32'(mem_we), 32'(m_mwe));
                check("mem_size", 32'(mem_size), 32'(m_msize));
                if (m_mwe) check("mem_wdata", mem_wdata, m_mwdata);
            end

            e_rsp = m_pending && (cyc == m_rsp_cyc);
            check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            if (e_rsp) begin
                check("rsp_port", 32'(rsp_port), 32'(m_port));
                check("rsp_fault", 32'(rsp_fault), 32'(m_fault));
                if (m_fault) check("rsp_cause", 32'(rsp_cause), 32'(m_cause));
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_tval", rsp_tval, m_tval);
                m_pending = 1'b0;
            end

            if (e_idle && (e_gf || e_gd)) begin
                a_we   = e_gd && d_we;
                a_addr = e_gd ? d_addr : if_addr;
                a_size = e_gd ? d_size : 2'b10;
                a_base = !e_gd ? 4'd0 : (a_we ? 4'd6 : 4'd4);
                a_mis  = (a_size == 2'b11) || (a_size == 2'b01 && a_addr[0]) ||
                         (a_size == 2'b10 && a_addr[1:0] != 2'b00);
                m_last    = e_gd;
                m_pending = 1'b1;
                m_port    = e_gd;
                m_paddr   = a_addr;
                m_poper   = !e_gd ? OP_EXEC : (a_we ? OP_WRITE : OP_READ);
                m_psize   = a_size;
                m_ppriv   = priv_mode;
                m_mwe     = a_we;
                m_maddr   = a_addr;
                m_mwdata  = d_wdata;
                m_msize   = a_size;
                m_issue   = 1'b0;
                m_fault   = 1'b1;
                m_rdata   = '0;
                m_tval    = a_addr;
                if (a_mis) begin
                    m_cause   = a_base;
                    m_rsp_cyc = cyc + 2;
                end else if (cfg_perm != 2'b01) begin
                    m_cause   = a_base + 4'd1;
                    m_rsp_cyc = cyc + 2;
                end else begin
                    m_issue  = 1'b1;
                    m_iss_lo = cyc + 2;
                    m_iss_hi = cyc + 2 + cfg_rw;
                    if (cfg_nores || cfg_w >= TIMEOUT) begin
                        m_cause   = a_base + 4'd1;
                        m_rsp_cyc = cyc + 3 + cfg_rw + TIMEOUT;
                    end else begin
                        m_fault   = 1'b0;
                        m_cause   = '0;
                        m_tval    = '0;
                        m_rdata   = a_we ? 32'd0 : cfg_rdata;
                        m_rsp_cyc = cyc + 4 + cfg_rw + cfg_w;
                    end
                end
            end
        end
    end

    bit saw_mreq = 1'b0;
    always @(negedge clock) if (mem_req_valid) saw_mreq = 1'b1;

    // -------------------------------------------------------------------------
    // Driver helpers
    // -------------------------------------------------------------------------
    bit          r_port, r_fault;
    logic [3:0]  r_cause;
    logic [31:0] r_rdata, r_tval;

    task automatic send(input bit use_f, input bit use_d, input logic [31:0] fa,
                        input bit we, input logic [31:0] da, input logic [1:0] sz,
                        output bit got_d, output int acc);
        @(posedge clock); #1;
        if_valid = use_f; if_addr = fa;
        d_valid = use_d; d_we = we; d_addr = da; d_size = sz; d_wdata = $urandom;
        priv_mode = 2'($urandom);
        acc = -1; got_d = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (if_ready || d_ready) begin acc = cyc; got_d = d_ready; break; end
        end
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL accept_wait: no ready within 50 cycles");
        end
        @(posedge clock); #1;
        if_valid = 1'b0; d_valid = 1'b0; priv_mode = 2'($urandom);
    endtask

    task automatic wait_rsp(output int rc);
        rc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                rc = cyc; r_port = rsp_port; r_fault = rsp_fault;
                r_cause = rsp_cause; r_rdata = rsp_rdata; r_tval = rsp_tval;
                break;
            end
        end
        if (rc < 0) begin
            total++; bad++;
            $display("FAIL rsp_wait: no rsp_valid within 300 cycles");
        end
    endtask

    task automatic set_cfg(input logic [1:0] perm, input int rw, input int w,
                           input bit nores, input logic [31:0] rd);
        cfg_perm = perm; cfg_rw = rw; cfg_w = w; cfg_nores = nores; cfg_rdata = rd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        bit gd;
        int acc, rc, prev_rc, found;
        logic [31:0] ra;

        repeat (3) @(posedge clock);
        #3 reset = 1'b1;

        // Fetch, granted, one-cycle memory response.
        set_cfg(2'b01, 0, 0, 1'b0, 32'hDEADBEEF);
        send(1'b1, 1'b0, 32'h2000_0000, 1'b0, 32'h0, 2'b10, gd, acc);
        check("t1_oper", 32'(pmp_oper), 32'(OP_EXEC));
        wait_rsp(rc);
        check("t1_latency", 32'(rc - acc), 32'd4);
        check("t1_rdata", r_rdata, 32'hDEADBEEF);
        check("t1_fault", 32'(r_fault), 32'd0);
        check("t1_port", 32'(r_port), 32'd0);

        // Both ports held valid: grants alternate data, fetch, data, fetch.
        set_cfg(2'b01, 0, 1, 1'b0, 32'h1234_5678);
        @(posedge clock); #1;
        if_valid = 1'b1; if_addr = 32'h2000_0100;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h4000_0000; d_size = 2'b10;
        prev_rc = -1;
        for (int k = 0; k < 4; k++) begin
            acc = -1;
            for (int i = 0; i < 50; i++) begin
                @(negedge clock);
                if (if_ready || d_ready) begin acc = cyc; gd = d_ready; break; end
            end
            check("alt_grant", 32'(gd), 32'(k % 2 == 0));
            if (prev_rc >= 0) check("alt_back_to_back", 32'(acc), 32'(prev_rc + 1));
            wait_rsp(rc);
            check("alt_rsp_port", 32'(r_port), 32'(k % 2 == 0));
            prev_rc = rc;
        end
        @(posedge clock); #1;
        if_valid = 1'b0; d_valid = 1'b0;

        // Misaligned store word; misalignment wins over a granting pmp.
        set_cfg(2'b01, 0, 0, 1'b0, 32'h0);
        saw_mreq = 1'b0;
        send(1'b0, 1'b1, 32'h0, 1'b1, 32'h2000_0001, 2'b10, gd, acc);
        wait_rsp(rc);
        check("t2_fault", 32'(r_fault), 32'd1);
        check("t2_cause", 32'(r_cause), 32'd6);
        check("t2_tval", r_tval, 32'h2000_0001);
        check("t2_latency", 32'(rc - acc), 32'd2);
        check("t2_no_mem_req", 32'(saw_mreq), 32'd0);

        // Load half denied by pmp.
        set_cfg(2'b00, 0, 0, 1'b0, 32'hFFFF_FFFF);
        send(1'b0, 1'b1, 32'h0, 1'b0, 32'h3000_0000, 2'b01, gd, acc);
        wait_rsp(rc);
        check("t3_cause", 32'(r_cause), 32'd5);
        check("t3_tval", r_tval, 32'h3000_0000);
        check("t3_rdata", r_rdata, 32'd0);

        // Load with no memory response: timeout 64 cycles after WAIT_MEM entry.
        set_cfg(2'b01, 0, 0, 1'b1, 32'h0);
        send(1'b0, 1'b1, 32'h0, 1'b0, 32'h3000_0004, 2'b10, gd, acc);
        wait_rsp(rc);
        check("t5_latency", 32'(rc - acc), 32'd67);
        check("t5_fault", 32'(r_fault), 32'd1);
        check("t5_cause", 32'(r_cause), 32'd5);

        // Response in the final allowed cycle beats the timeout.
        set_cfg(2'b01, 0, TIMEOUT - 1, 1'b0, 32'hCAFE_F00D);
        send(1'b0, 1'b1, 32'h0, 1'b0, 32'h3000_0008, 2'b10, gd, acc);
        wait_rsp(rc);
        check("t6_latency", 32'(rc - acc), 32'd67);
        check("t6_fault", 32'(r_fault), 32'd0);
        check("t6_rdata", r_rdata, 32'hCAFE_F00D);

        // Reset while in ISSUE aborts the transaction.
        set_cfg(2'b01, 20, 0, 1'b0, 32'h0);
        send(1'b0, 1'b1, 32'h0, 1'b0, 32'h5000_0000, 2'b10, gd, acc);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (mem_req_valid) begin found = 1; break; end
        end
        check("t7_reached_issue", 32'(found), 32'd1);
        @(posedge clock); #3 reset = 1'b0;
        #1;
        check("t7_mem_req_dropped", 32'(mem_req_valid), 32'd0);
        check("t7_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        set_cfg(2'b01, 1, 2, 1'b0, 32'hA5A5_0001);
        send(1'b0, 1'b1, 32'h0, 1'b0, 32'h5000_0010, 2'b10, gd, acc);
        wait_rsp(rc);
        check("t7_after_fault", 32'(r_fault), 32'd0);
        check("t7_after_rdata", r_rdata, 32'hA5A5_0001);
        check("t7_after_latency", 32'(rc - acc), 32'd7);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 60; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            set_cfg(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 19) == 0), $urandom);
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            send(mode != 1, mode != 0, {ra[31:2], 2'b00}, 1'($urandom), ra,
                 2'($urandom), gd, acc);
            wait_rsp(rc);
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
